// File: rtl/remainder_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, WIDTH+1 cycle latency.
// Optional macro DIV_ZERO_DETECT_EN short-circuits a zero divisor straight to DONE with a flag.
module remainder_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend_in,
  input  logic [WIDTH-1:0] Divisor_in,
  output logic             Busy,
  output logic             Ready,
  output logic [WIDTH-1:0] Quotient_out,
  output logic [WIDTH-1:0] Remainder_out,
  output logic             Div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r, state_next_s;
  logic [CW-1:0]      count_r, count_next_s;
  logic [2*WIDTH-1:0] rem_r, rem_next_s;
  logic [WIDTH-1:0]   divisor_r, divisor_next_s;
  logic               last_step_s;
  logic               zero_start_s;
  logic               busy_next_s, ready_next_s, dz_next_s;
  logic [WIDTH-1:0]   quot_next_s, remd_next_s;

  // Shift left, trial-subtract from the upper WIDTH+1 bits, keep or restore.
  function automatic logic [2*WIDTH-1:0] restore_step(input logic [2*WIDTH-1:0] rem,
                                                       input logic [WIDTH-1:0]   dvs);
    logic [WIDTH:0] diff;
    diff = rem[2*WIDTH-1:WIDTH-1] - {1'b0, dvs};
    if (diff[WIDTH]) begin
      restore_step = {rem[2*WIDTH-2:0], 1'b0};
    end else begin
      restore_step = {diff[WIDTH-1:0], rem[WIDTH-2:0], 1'b1};
    end
  endfunction

`ifdef DIV_ZERO_DETECT_EN
  assign zero_start_s = (Divisor_in == {WIDTH{1'b0}});
`else
  assign zero_start_s = 1'b0;
`endif

  assign last_step_s = (count_r == CW'(WIDTH - 1));

  // FSM state register
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (Start) begin
          state_next_s = zero_start_s ? DONE : CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (last_step_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = CALC;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Datapath next values: operand capture and one restoring step per CALC cycle
  always_comb begin
    rem_next_s     = rem_r;
    count_next_s   = count_r;
    divisor_next_s = divisor_r;
    case (state_r)
      IDLE: begin
        if (Start) begin
          divisor_next_s = Divisor_in;
          count_next_s   = {CW{1'b0}};
          // A detected zero divisor preloads the final answer: all-ones quotient, dividend remainder.
          rem_next_s     = zero_start_s ? {Dividend_in, {WIDTH{1'b1}}}
                                        : {{WIDTH{1'b0}}, Dividend_in};
        end else begin
          rem_next_s     = rem_r;
        end
      end
      CALC: begin
        rem_next_s   = restore_step(rem_r, divisor_r);
        count_next_s = last_step_s ? {CW{1'b0}} : count_r + CW'(1);
      end
      DONE:    rem_next_s = rem_r;
      default: rem_next_s = rem_r;
    endcase
  end

  // Output next values, derived from the state being entered so outputs can be registered
  always_comb begin
    busy_next_s  = (state_next_s != IDLE);
    ready_next_s = (state_next_s == DONE);
    quot_next_s  = Quotient_out;
    remd_next_s  = Remainder_out;
    dz_next_s    = Div_by_zero;
    if (state_next_s == DONE) begin
      quot_next_s = rem_next_s[WIDTH-1:0];
      remd_next_s = rem_next_s[2*WIDTH-1:WIDTH];
      dz_next_s   = (state_r == IDLE) && zero_start_s;
    end else begin
      quot_next_s = Quotient_out;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rem_r     <= {(2*WIDTH){1'b0}};
      count_r   <= {CW{1'b0}};
      divisor_r <= {WIDTH{1'b0}};
    end else begin
      rem_r     <= rem_next_s;
      count_r   <= count_next_s;
      divisor_r <= divisor_next_s;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Busy          <= 1'b0;
      Ready         <= 1'b0;
      Quotient_out  <= {WIDTH{1'b0}};
      Remainder_out <= {WIDTH{1'b0}};
      Div_by_zero   <= 1'b0;
    end else begin
      Busy          <= busy_next_s;
      Ready         <= ready_next_s;
      Quotient_out  <= quot_next_s;
      Remainder_out <= remd_next_s;
      Div_by_zero   <= dz_next_s;
    end
  end

endmodule
